// File: rtl/ysyx_22040125_mem_arb.sv
// ysyx_22040125_mem_arb: single-outstanding arbiter sharing one memory port between IF and MEM requesters
// Ports: clk/rst (async active-high); i_if_* / o_if_* fetch side; i_mem_* / o_mem_* load/store side;
//        o_bus_* / i_bus_* downstream valid/ready request with response strobe; o_busy = not idle.
// Optional: define YSYX_22040125_ARB_RR_EN for two-way round-robin on ties (default: MEM wins ties).
module ysyx_22040125_mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_mem_req,
  input  logic                i_mem_wen,
  input  logic [ADDR_W-1:0]   i_mem_addr,
  input  logic [DATA_W-1:0]   i_mem_wdata,
  input  logic [DATA_W/8-1:0] i_mem_wmask,
  output logic                o_mem_gnt,
  output logic                o_mem_rvalid,
  output logic [DATA_W-1:0]   o_mem_rdata,
  output logic                o_bus_valid,
  input  logic                i_bus_ready,
  output logic                o_bus_wen,
  output logic [ADDR_W-1:0]   o_bus_addr,
  output logic [DATA_W-1:0]   o_bus_wdata,
  output logic [DATA_W/8-1:0] o_bus_wmask,
  input  logic                i_bus_rvalid,
  input  logic [DATA_W-1:0]   i_bus_rdata,
  output logic                o_busy
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t r_state, w_next;
  logic                r_owner_mem;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic                r_if_rvalid, r_mem_rvalid;
  logic [DATA_W-1:0]   r_if_rdata, r_mem_rdata;
  logic                w_pick_mem, w_gnt, w_done;
`ifdef YSYX_22040125_ARB_RR_EN
  logic r_last_mem;
  // On a tie, serve whoever was not served last; reset state means IF wins the first tie.
  assign w_pick_mem = i_mem_req & (~i_if_req | ~r_last_mem);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_last_mem <= 1'b1;
    else if (w_gnt) r_last_mem <= o_mem_gnt;
`else
  assign w_pick_mem = i_mem_req;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next    = r_state;
    o_if_gnt  = 1'b0;
    o_mem_gnt = 1'b0;
    case (r_state)
      IDLE: begin
        o_mem_gnt = w_pick_mem;
        o_if_gnt  = i_if_req & ~w_pick_mem;
        w_next    = (i_if_req | i_mem_req) ? REQ : IDLE;
      end
      REQ:     w_next = i_bus_ready ? RESP : REQ;
      RESP:    w_next = i_bus_rvalid ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  assign w_gnt  = o_if_gnt | o_mem_gnt;
  assign w_done = (r_state == RESP) & i_bus_rvalid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_owner_mem  <= 1'b1;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_if_rvalid  <= 1'b0;
      r_mem_rvalid <= 1'b0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
    end else begin
      if (w_gnt) begin
        r_owner_mem <= o_mem_gnt;
        r_wen       <= o_mem_gnt & i_mem_wen;
        r_addr      <= o_mem_gnt ? i_mem_addr : i_if_addr;
        r_wdata     <= o_mem_gnt ? i_mem_wdata : '0;
        r_wmask     <= (o_mem_gnt & i_mem_wen) ? i_mem_wmask : '0;
      end
      r_if_rvalid  <= w_done & ~r_owner_mem;
      r_mem_rvalid <= w_done & r_owner_mem;
      if (w_done & ~r_owner_mem) r_if_rdata <= i_bus_rdata;
      // Stores return no data, so the load-data register is cleared for them.
      if (w_done & r_owner_mem) r_mem_rdata <= r_wen ? '0 : i_bus_rdata;
    end
  assign o_bus_valid  = (r_state == REQ);
  assign o_busy       = (r_state != IDLE);
  assign o_bus_wen    = r_wen;
  assign o_bus_addr   = r_addr;
  assign o_bus_wdata  = r_wdata;
  assign o_bus_wmask  = r_wmask;
  assign o_if_rvalid  = r_if_rvalid;
  assign o_if_rdata   = r_if_rdata;
  assign o_mem_rvalid = r_mem_rvalid;
  assign o_mem_rdata  = r_mem_rdata;
endmodule

// File: tb/tb_ysyx_22040125_mem_arb.sv
// tb_ysyx_22040125_mem_arb: directed self-checking bench for the IF/MEM memory arbiter
module tb_ysyx_22040125_mem_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_gnt, if_rvalid;
  logic [31:0] if_addr = '0;
  logic [63:0] if_rdata;
  logic        mem_req = 1'b0, mem_wen = 1'b0, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0, mem_rdata;
  logic [7:0]  mem_wmask = '0;
  logic        bus_valid, bus_ready = 1'b0, bus_wen, bus_rvalid = 1'b0, busy;
  logic [31:0] bus_addr;
  logic [63:0] bus_wdata, bus_rdata = '0;
  logic [7:0]  bus_wmask;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  ysyx_22040125_mem_arb dut (
    .clk(clk), .rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_mem_req(mem_req), .i_mem_wen(mem_wen), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .i_mem_wmask(mem_wmask), .o_mem_gnt(mem_gnt), .o_mem_rvalid(mem_rvalid), .o_mem_rdata(mem_rdata),
    .o_bus_valid(bus_valid), .i_bus_ready(bus_ready), .o_bus_wen(bus_wen), .o_bus_addr(bus_addr),
    .o_bus_wdata(bus_wdata), .o_bus_wmask(bus_wmask), .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata),
    .o_busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  // Called in the cycle after a grant: handshake now, response next cycle, returns at R+1.
  task automatic serve(input logic [63:0] d);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata = d;
    step();
    bus_rvalid = 1'b0;
  endtask
  initial begin
    logic exp_mem;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_idle", {busy, bus_valid, if_rvalid, mem_rvalid, if_gnt, mem_gnt}, 6'b0);
    // single IF fetch, zero wait states
    if_req = 1'b1;
    if_addr = 32'h8000_0000;
    #1;
    chk("if_gnt", {if_gnt, mem_gnt}, 2'b10);
    step();
    if_req = 1'b0;
    #1;
    chk("if_req_cmd", {bus_valid, bus_wen, bus_wmask, bus_addr}, {1'b1, 1'b0, 8'h00, 32'h8000_0000});
    chk("if_wdata", bus_wdata, 64'h0);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata = 64'h0000_0013_0010_0093;
    #1;
    chk("if_resp_state", {bus_valid, busy}, 2'b01);
    step();
    bus_rvalid = 1'b0;
    #1;
    chk("if_rv", {if_rvalid, mem_rvalid, busy}, 3'b100);
    chk("if_rdata", if_rdata, 64'h0000_0013_0010_0093);
    step();
    #1;
    chk("if_rv_pulse", {if_rvalid, mem_rvalid}, 2'b00);
    chk("if_rdata_hold", if_rdata, 64'h0000_0013_0010_0093);
    // MEM store with three wait states
    mem_req = 1'b1;
    mem_wen = 1'b1;
    mem_addr = 32'h8000_1008;
    mem_wdata = 64'h1122_3344_5566_7788;
    mem_wmask = 8'hF0;
    #1;
    chk("st_gnt", {if_gnt, mem_gnt}, 2'b01);
    step();
    mem_req = 1'b0;
    mem_wdata = '0;
    mem_addr = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("st_cmd", {bus_valid, bus_wen, bus_wmask, bus_addr}, {1'b1, 1'b1, 8'hF0, 32'h8000_1008});
      chk("st_wdata", bus_wdata, 64'h1122_3344_5566_7788);
      bus_ready = (k == 3);
      step();
    end
    bus_ready = 1'b0;
    #1;
    chk("st_resp_valid", {bus_valid, busy}, 2'b01);
    bus_rvalid = 1'b1;
    bus_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    bus_rvalid = 1'b0;
    #1;
    chk("st_rv", {mem_rvalid, if_rvalid}, 2'b10);
    chk("st_rdata", mem_rdata, 64'h0);
    step();
    #1;
    chk("st_rv_pulse", mem_rvalid, 1'b0);
    // simultaneous requests for 6 transactions, from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_wen = 1'b0;
    mem_addr = 32'h8000_3000;
    if_addr = 32'h8000_0100;
    if_req = 1'b1;
    mem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
`ifdef YSYX_22040125_ARB_RR_EN
      exp_mem = (i % 2 == 1);
`else
      exp_mem = 1'b1;
`endif
      #1;
      chk("tie_gnt", {mem_gnt, if_gnt}, exp_mem ? 2'b10 : 2'b01);
      step();
      serve(64'h100 + 64'(i));
      #1;
      chk("tie_rv", {mem_rvalid, if_rvalid}, exp_mem ? 2'b10 : 2'b01);
      chk("tie_rdata", exp_mem ? mem_rdata : if_rdata, 64'h100 + 64'(i));
    end
    if_req = 1'b0;
    mem_req = 1'b0;
    step();
    // stray responses in IDLE and REQ are ignored
    bus_rvalid = 1'b1;
    bus_rdata = 64'hBAD0;
    step();
    bus_rvalid = 1'b0;
    #1;
    chk("stray_idle", {if_rvalid, mem_rvalid, busy}, 3'b000);
    if_req = 1'b1;
    if_addr = 32'h8000_0200;
    #1;
    chk("stray_gnt", if_gnt, 1'b1);
    step();
    if_req = 1'b0;
    bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
    #1;
    chk("stray_req", {bus_valid, if_rvalid, mem_rvalid}, 3'b100);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    step();
    #1;
    chk("late_wait", {busy, bus_valid, if_rvalid}, 3'b100);
    bus_rvalid = 1'b1;
    bus_rdata = 64'h5555_6666_7777_8888;
    step();
    bus_rvalid = 1'b0;
    #1;
    chk("late_rv", {if_rvalid, mem_rvalid, busy}, 3'b100);
    chk("late_rdata", if_rdata, 64'h5555_6666_7777_8888);
    // reset while waiting for a response
    mem_req = 1'b1;
    mem_addr = 32'h8000_4000;
    #1;
    chk("rr_gnt", mem_gnt, 1'b1);
    step();
    mem_req = 1'b0;
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    rst = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata = 64'h9999;
    #1;
    chk("rst_ctl", {busy, bus_valid, bus_wen, if_rvalid, mem_rvalid, if_gnt, mem_gnt}, 7'b0);
    chk("rst_cmd", {bus_addr, bus_wmask}, 40'h0);
    chk("rst_wdata", bus_wdata, 64'h0);
    chk("rst_rdata", if_rdata | mem_rdata, 64'h0);
    step();
    rst = 1'b0;
    step();
    bus_rvalid = 1'b0;
    #1;
    chk("rst_after", {if_rvalid, mem_rvalid, busy}, 3'b000);
    if_req = 1'b1;
    if_addr = 32'h8000_0300;
    #1;
    chk("rst_regnt", if_gnt, 1'b1);
    step();
    if_req = 1'b0;
    serve(64'h1234);
    #1;
    chk("rst_rv", {if_rvalid, if_rdata}, {1'b1, 64'h1234});
    // MEM load then a pending IF request granted in the response cycle
    mem_req = 1'b1;
    mem_wen = 1'b0;
    mem_addr = 32'h8000_2000;
    #1;
    chk("ld_gnt", {mem_gnt, if_gnt}, 2'b10);
    step();
    mem_req = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h8000_0400;
    #1;
    chk("ld_no_gnt_busy", {if_gnt, bus_wmask}, 9'h0);
    serve(64'hDEAD_BEEF_CAFE_F00D);
    #1;
    chk("ld_rv_gnt", {mem_rvalid, if_gnt, if_rvalid}, 3'b110);
    chk("ld_rdata", mem_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    step();
    if_req = 1'b0;
    #1;
    chk("ld_if_cmd", {bus_valid, bus_addr}, {1'b1, 32'h8000_0400});
    serve(64'h77);
    #1;
    chk("ld_if_rv", {if_rvalid, mem_rvalid, if_rdata}, {2'b10, 64'h77});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ysyx_22040125_mem_arb.md
# ysyx_22040125_mem_arb

Single-outstanding arbiter that shares one downstream memory port between the instruction-fetch requester (IF) and the load/store requester (MEM stage) of the 5-stage RV64 core. It selects one requester, captures its command, drives a valid/ready request to the memory, waits for the response and routes it back to the owner. It replaces the separate fetch and data paths into the RAM model once that model gains multi-cycle latency.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 64, data width; byte mask width is DATA_W/8

- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  IF request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle grant; command captured this cycle
- if_rvalid  out  1  one-cycle response strobe
- if_rdata  out  DATA_W  fetch data, valid with if_rvalid
- mem_req  in  1  MEM request; held until mem_gnt
- mem_wen  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_wmask  in  DATA_W/8  store byte enables
- mem_gnt  out  1  one-cycle grant
- mem_rvalid  out  1  one-cycle response strobe (loads and stores)
- mem_rdata  out  DATA_W  load data, valid with mem_rvalid
- bus_valid  out  1  downstream request valid
- bus_ready  in  1  downstream accepts when bus_valid & bus_ready
- bus_wen, bus_addr, bus_wdata, bus_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  captured command
- bus_rvalid  in  1  downstream response strobe
- bus_rdata  in  DATA_W  downstream read data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, RESP. Owner register (IF/MEM) set at grant.
- IDLE: if any req, grant exactly one (combinational gnt), capture addr/wen/wdata/wmask into command registers, go REQ. IF commands: bus_wen=0, bus_wmask=0, bus_wdata=0. MEM loads: bus_wmask forced 0.
- REQ: bus_valid=1, command registers stable; on bus_valid & bus_ready go RESP.
- RESP: bus_valid=0; on bus_rvalid go IDLE, register owner's rvalid=1 and rdata=bus_rdata for one cycle next cycle; for a MEM store mem_rdata loads 0.
- Selection: both requests in IDLE -> MEM wins (fixed priority) unless round-robin configured.
- Non-owner rvalid never asserts; if_rdata/mem_rdata hold value between responses.
- bus_rvalid in IDLE or REQ ignored; bus_ready outside REQ ignored.
- Requester dropping req before gnt: no grant, no state change.
- Reset (any state, including mid-transaction): state IDLE, all outputs 0, command/data registers 0, owner=MEM, RR pointer = "MEM last served"; in-flight transaction abandoned, no rvalid emitted after reset.

## Timing
- Grant in cycle T (IDLE, req high); bus_valid from T+1.
- bus_valid held until handshake; zero wait states if bus_ready high at T+1.
- bus_rvalid at cycle R -> owner rvalid/rdata at R+1; state IDLE at R+1, so a new grant may occur at R+1.
- Minimum occupancy: grant T, handshake T+1, bus_rvalid T+2, rvalid T+3, next grant T+3 (3-cycle throughput).
- Exactly one transaction outstanding; gnt never asserts while busy=1.

## Configuration
- YSYX_22040125_ARB_RR_EN defined: two-way round-robin; on simultaneous requests grant the requester not served last; pointer updates on every grant; after reset IF wins first tie.
- Not defined: fixed priority, MEM always wins ties; pointer logic absent; IF may starve under continuous MEM requests.

## Test plan
- Single IF fetch, addr 0x80000000, bus_ready=1 at T+1, bus_rvalid at T+2 with 0x00000013_00100093 -> if_gnt at T, bus_valid T+1 only, if_rvalid=1 and if_rdata=0x0000001300100093 at T+3, mem_rvalid=0.
- MEM store addr 0x80001008, wdata 0x1122334455667788, wmask 0xF0, bus_ready delayed 3 cycles -> bus_valid high 4 cycles with stable command, mem_rvalid one cycle after bus_rvalid, mem_rdata=0.
- if_req and mem_req both held high for 6 transactions -> fixed: all 6 to MEM; with YSYX_22040125_ARB_RR_EN: IF, MEM, IF, MEM, IF, MEM.
- Stray bus_rvalid in IDLE and during REQ -> no rvalid, state unchanged; late genuine response handled normally.
- rst asserted in RESP, bus_rvalid arrives next cycle while rst high then low -> all outputs 0, no if_rvalid/mem_rvalid, busy=0, next request granted normally.
- MEM load 0x80002000 returning 0xDEADBEEFCAFEF00D followed immediately by pending IF req -> mem_rvalid and if_gnt in same cycle.
